// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared requester indices and FSM encoding for mem_burst_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] REQ_CH0_WR = 2'd0;
    localparam logic [1:0] REQ_CH0_RD = 2'd1;
    localparam logic [1:0] REQ_CH1_WR = 2'd2;
    localparam logic [1:0] REQ_CH1_RD = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_burst_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational round-robin pick of the first request at/after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_rr_ptr,
    output logic       o_found,
    output logic [1:0] o_index
);

    logic [1:0] w_cand;

    // Walk from the farthest candidate back to the pointer so the closest wins.
    always_comb begin
        o_index = i_rr_ptr;
        o_found = 1'b0;
        w_cand  = i_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = i_rr_ptr + 2'(i);
            if (i_req[w_cand]) begin
                o_index = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_arbiter
// Brief    : Round-robin sharing of one DDR3 burst port by two frame channels.
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 25,
    parameter int BUSRT_BITS    = 10
) (
    input  logic                     mem_clk,
    input  logic                     rst,

    input  logic                     ch0_rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    ch0_rd_burst_len,
    input  logic [ADDR_BITS-1:0]     ch0_rd_burst_addr,
    output logic                     ch0_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch0_rd_burst_data,
    output logic                     ch0_rd_burst_finish,
    input  logic                     ch0_wr_burst_req,
    input  logic [BUSRT_BITS-1:0]    ch0_wr_burst_len,
    input  logic [ADDR_BITS-1:0]     ch0_wr_burst_addr,
    output logic                     ch0_wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] ch0_wr_burst_data,
    output logic                     ch0_wr_burst_finish,

    input  logic                     ch1_rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    ch1_rd_burst_len,
    input  logic [ADDR_BITS-1:0]     ch1_rd_burst_addr,
    output logic                     ch1_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch1_rd_burst_data,
    output logic                     ch1_rd_burst_finish,
    input  logic                     ch1_wr_burst_req,
    input  logic [BUSRT_BITS-1:0]    ch1_wr_burst_len,
    input  logic [ADDR_BITS-1:0]     ch1_wr_burst_addr,
    output logic                     ch1_wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] ch1_wr_burst_data,
    output logic                     ch1_wr_burst_finish,

    output logic                     rd_burst_req,
    output logic [BUSRT_BITS-1:0]    rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     wr_burst_req,
    output logic [BUSRT_BITS-1:0]    wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,

    output logic [3:0]               arb_grant
);

    arb_state_t              r_state;
    logic [1:0]              r_rr_ptr;
    logic [1:0]              r_grant;

    logic [3:0]              w_req;
    logic                    w_pick_found;
    logic [1:0]              w_pick_idx;
    logic [ADDR_BITS-1:0]    w_sel_addr;
    logic [BUSRT_BITS-1:0]   w_sel_len;
    logic                    w_busy;
    logic                    w_done;

    assign w_req = {ch1_rd_burst_req, ch1_wr_burst_req, ch0_rd_burst_req, ch0_wr_burst_req};

    rr_pick4 u_pick (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_pick_found),
        .o_index  (w_pick_idx)
    );

    always_comb begin
        w_sel_addr = ch0_wr_burst_addr;
        w_sel_len  = ch0_wr_burst_len;
        case (w_pick_idx)
            REQ_CH0_WR: begin w_sel_addr = ch0_wr_burst_addr; w_sel_len = ch0_wr_burst_len; end
            REQ_CH0_RD: begin w_sel_addr = ch0_rd_burst_addr; w_sel_len = ch0_rd_burst_len; end
            REQ_CH1_WR: begin w_sel_addr = ch1_wr_burst_addr; w_sel_len = ch1_wr_burst_len; end
            default:    begin w_sel_addr = ch1_rd_burst_addr; w_sel_len = ch1_rd_burst_len; end
        endcase
    end

    // Index bit 0 marks a read requester; only that direction's finish ends the burst.
    assign w_busy = (r_state == BUSY);
    assign w_done = r_grant[0] ? rd_burst_finish : wr_burst_finish;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rr_ptr      <= 2'd0;
            r_grant       <= 2'd0;
            arb_grant     <= 4'd0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            rd_burst_len  <= '0;
            wr_burst_addr <= '0;
            wr_burst_len  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_grant   <= w_pick_idx;
                        arb_grant <= 4'b0001 << w_pick_idx;
                        if (w_pick_idx[0]) begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_addr <= w_sel_addr;
                            rd_burst_len  <= w_sel_len;
                        end else begin
                            wr_burst_req  <= 1'b1;
                            wr_burst_addr <= w_sel_addr;
                            wr_burst_len  <= w_sel_len;
                        end
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        rd_burst_req <= 1'b0;
                        wr_burst_req <= 1'b0;
                        r_rr_ptr     <= r_grant + 2'd1;
                        arb_grant    <= 4'd0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ch0_rd_burst_data_valid = w_busy && (r_grant == REQ_CH0_RD) && rd_burst_data_valid;
    assign ch0_rd_burst_finish     = w_busy && (r_grant == REQ_CH0_RD) && rd_burst_finish;
    assign ch1_rd_burst_data_valid = w_busy && (r_grant == REQ_CH1_RD) && rd_burst_data_valid;
    assign ch1_rd_burst_finish     = w_busy && (r_grant == REQ_CH1_RD) && rd_burst_finish;
    assign ch0_wr_burst_data_req   = w_busy && (r_grant == REQ_CH0_WR) && wr_burst_data_req;
    assign ch0_wr_burst_finish     = w_busy && (r_grant == REQ_CH0_WR) && wr_burst_finish;
    assign ch1_wr_burst_data_req   = w_busy && (r_grant == REQ_CH1_WR) && wr_burst_data_req;
    assign ch1_wr_burst_finish     = w_busy && (r_grant == REQ_CH1_WR) && wr_burst_finish;

    assign ch0_rd_burst_data = rd_burst_data;
    assign ch1_rd_burst_data = rd_burst_data;
    assign wr_burst_data     = r_grant[1] ? ch1_wr_burst_data : ch0_wr_burst_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_arbiter
// Brief    : Directed self-checking bench for mem_burst_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_arbiter;

    logic        mem_clk = 1'b0;
    logic        rst;

    logic        ch0_rd_burst_req, ch0_wr_burst_req, ch1_rd_burst_req, ch1_wr_burst_req;
    logic [9:0]  ch0_rd_burst_len, ch0_wr_burst_len, ch1_rd_burst_len, ch1_wr_burst_len;
    logic [24:0] ch0_rd_burst_addr, ch0_wr_burst_addr, ch1_rd_burst_addr, ch1_wr_burst_addr;
    logic        ch0_rd_burst_data_valid, ch1_rd_burst_data_valid;
    logic [63:0] ch0_rd_burst_data, ch1_rd_burst_data;
    logic        ch0_rd_burst_finish, ch1_rd_burst_finish;
    logic        ch0_wr_burst_data_req, ch1_wr_burst_data_req;
    logic [63:0] ch0_wr_burst_data, ch1_wr_burst_data;
    logic        ch0_wr_burst_finish, ch1_wr_burst_finish;

    logic        rd_burst_req, wr_burst_req;
    logic [9:0]  rd_burst_len, wr_burst_len;
    logic [24:0] rd_burst_addr, wr_burst_addr;
    logic        rd_burst_data_valid, rd_burst_finish;
    logic [63:0] rd_burst_data, wr_burst_data;
    logic        wr_burst_data_req, wr_burst_finish;
    logic [3:0]  arb_grant;

    int n_pass  = 0;
    int n_total = 0;

    mem_burst_arbiter dut (
        .mem_clk                 (mem_clk),
        .rst                     (rst),
        .ch0_rd_burst_req        (ch0_rd_burst_req),
        .ch0_rd_burst_len        (ch0_rd_burst_len),
        .ch0_rd_burst_addr       (ch0_rd_burst_addr),
        .ch0_rd_burst_data_valid (ch0_rd_burst_data_valid),
        .ch0_rd_burst_data       (ch0_rd_burst_data),
        .ch0_rd_burst_finish     (ch0_rd_burst_finish),
        .ch0_wr_burst_req        (ch0_wr_burst_req),
        .ch0_wr_burst_len        (ch0_wr_burst_len),
        .ch0_wr_burst_addr       (ch0_wr_burst_addr),
        .ch0_wr_burst_data_req   (ch0_wr_burst_data_req),
        .ch0_wr_burst_data       (ch0_wr_burst_data),
        .ch0_wr_burst_finish     (ch0_wr_burst_finish),
        .ch1_rd_burst_req        (ch1_rd_burst_req),
        .ch1_rd_burst_len        (ch1_rd_burst_len),
        .ch1_rd_burst_addr       (ch1_rd_burst_addr),
        .ch1_rd_burst_data_valid (ch1_rd_burst_data_valid),
        .ch1_rd_burst_data       (ch1_rd_burst_data),
        .ch1_rd_burst_finish     (ch1_rd_burst_finish),
        .ch1_wr_burst_req        (ch1_wr_burst_req),
        .ch1_wr_burst_len        (ch1_wr_burst_len),
        .ch1_wr_burst_addr       (ch1_wr_burst_addr),
        .ch1_wr_burst_data_req   (ch1_wr_burst_data_req),
        .ch1_wr_burst_data       (ch1_wr_burst_data),
        .ch1_wr_burst_finish     (ch1_wr_burst_finish),
        .rd_burst_req            (rd_burst_req),
        .rd_burst_len            (rd_burst_len),
        .rd_burst_addr           (rd_burst_addr),
        .rd_burst_data_valid     (rd_burst_data_valid),
        .rd_burst_data           (rd_burst_data),
        .rd_burst_finish         (rd_burst_finish),
        .wr_burst_req            (wr_burst_req),
        .wr_burst_len            (wr_burst_len),
        .wr_burst_addr           (wr_burst_addr),
        .wr_burst_data_req       (wr_burst_data_req),
        .wr_burst_data           (wr_burst_data),
        .wr_burst_finish         (wr_burst_finish),
        .arb_grant               (arb_grant)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic cyc();
        @(posedge mem_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [24:0] exp_addr [4];
        logic [9:0]  exp_len  [4];
        int n0, n1, nbad, nleak;
        logic [1:0] g;

        exp_addr[0] = 25'h100; exp_len[0] = 10'd64;
        exp_addr[1] = 25'h200; exp_len[1] = 10'd16;
        exp_addr[2] = 25'h300; exp_len[2] = 10'd32;
        exp_addr[3] = 25'h400; exp_len[3] = 10'd8;

        rst = 1'b1;
        ch0_wr_burst_req = 0; ch0_rd_burst_req = 0; ch1_wr_burst_req = 0; ch1_rd_burst_req = 0;
        ch0_wr_burst_addr = exp_addr[0]; ch0_wr_burst_len = exp_len[0];
        ch0_rd_burst_addr = exp_addr[1]; ch0_rd_burst_len = exp_len[1];
        ch1_wr_burst_addr = exp_addr[2]; ch1_wr_burst_len = exp_len[2];
        ch1_rd_burst_addr = exp_addr[3]; ch1_rd_burst_len = exp_len[3];
        ch0_wr_burst_data = '0; ch1_wr_burst_data = '0;
        rd_burst_data_valid = 0; rd_burst_data = '0; rd_burst_finish = 0;
        wr_burst_data_req = 0; wr_burst_finish = 0;

        // Reset state
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_arb_grant", arb_grant, 4'b0000);
        chk("reset_rd_req", rd_burst_req, 1'b0);
        chk("reset_wr_req", wr_burst_req, 1'b0);
        chk("reset_wr_addr", wr_burst_addr, 25'h0);
        chk("reset_wr_len", wr_burst_len, 10'd0);
        chk("reset_rd_addr", rd_burst_addr, 25'h0);
        chk("reset_rd_len", rd_burst_len, 10'd0);

        // Controller strobes while idle must not reach any client
        wr_burst_data_req = 1; rd_burst_data_valid = 1; wr_burst_finish = 1; rd_burst_finish = 1;
        #1;
        chk("idle_leak", {ch0_wr_burst_data_req, ch1_wr_burst_data_req, ch0_rd_burst_data_valid,
                          ch1_rd_burst_data_valid, ch0_wr_burst_finish, ch1_wr_burst_finish,
                          ch0_rd_burst_finish, ch1_rd_burst_finish}, 8'h00);
        wr_burst_data_req = 0; rd_burst_data_valid = 0; wr_burst_finish = 0; rd_burst_finish = 0;

        // Single ch0_wr burst
        ch0_wr_burst_req = 1;
        #1;
        chk("t1_grant_before_edge", arb_grant, 4'b0000);
        cyc();
        chk("t1_arb_grant", arb_grant, 4'b0001);
        chk("t1_wr_req", wr_burst_req, 1'b1);
        chk("t1_rd_req", rd_burst_req, 1'b0);
        chk("t1_wr_addr", wr_burst_addr, 25'h100);
        chk("t1_wr_len", wr_burst_len, 10'd64);
        n0 = 0; n1 = 0; nbad = 0;
        for (int i = 0; i < 64; i++) begin
            wr_burst_data_req = 1;
            ch0_wr_burst_data = 64'hA000 + 64'(i);
            ch1_wr_burst_data = 64'hB000 + 64'(i);
            #1;
            if (ch0_wr_burst_data_req) n0++;
            if (ch1_wr_burst_data_req) n1++;
            if (wr_burst_data !== 64'hA000 + 64'(i)) nbad++;
            cyc();
        end
        wr_burst_data_req = 0;
        chk("t1_ch0_data_req_count", 64'(n0), 64'd64);
        chk("t1_ch1_data_req_count", 64'(n1), 64'd0);
        chk("t1_wr_data_mux_errors", 64'(nbad), 64'd0);
        wr_burst_finish = 1;
        #1;
        chk("t1_ch0_wr_finish", ch0_wr_burst_finish, 1'b1);
        chk("t1_ch1_wr_finish", ch1_wr_burst_finish, 1'b0);
        cyc();
        wr_burst_finish = 0; ch0_wr_burst_req = 0;
        chk("t1_wr_req_after_finish", wr_burst_req, 1'b0);
        chk("t1_arb_after_finish", arb_grant, 4'b0000);

        // All four requests held: order 0,1,2,3,0 with one idle cycle between
        rst = 1; cyc(); rst = 0;
        ch0_wr_burst_req = 1; ch0_rd_burst_req = 1; ch1_wr_burst_req = 1; ch1_rd_burst_req = 1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            g = 2'(k % 4);
            chk("t2_arb_grant", arb_grant, 4'b0001 << g);
            chk("t2_dir_req", {rd_burst_req, wr_burst_req}, g[0] ? 2'b10 : 2'b01);
            chk("t2_addr", g[0] ? rd_burst_addr : wr_burst_addr, exp_addr[g]);
            chk("t2_len", g[0] ? rd_burst_len : wr_burst_len, exp_len[g]);
            if (g[0]) rd_burst_finish = 1; else wr_burst_finish = 1;
            cyc();
            rd_burst_finish = 0; wr_burst_finish = 0;
            if (k == 4) begin
                ch0_wr_burst_req = 0; ch0_rd_burst_req = 0; ch1_wr_burst_req = 0; ch1_rd_burst_req = 0;
            end
            chk("t2_idle_gap_arb", arb_grant, 4'b0000);
            chk("t2_idle_gap_reqs", {rd_burst_req, wr_burst_req}, 2'b00);
            cyc();
        end
        chk("t2_quiet_after", arb_grant, 4'b0000);

        // ch1_rd burst with 32 valids and a stray write finish
        ch1_rd_burst_req = 1;
        cyc();
        chk("t3_arb_grant", arb_grant, 4'b1000);
        chk("t3_rd_req", rd_burst_req, 1'b1);
        chk("t3_rd_addr", rd_burst_addr, 25'h400);
        chk("t3_rd_len", rd_burst_len, 10'd8);
        n0 = 0; n1 = 0; nbad = 0; nleak = 0;
        for (int i = 0; i < 40; i++) begin
            rd_burst_data_valid = (i < 32);
            rd_burst_data = 64'(i * 3 + 7);
            wr_burst_finish = (i == 10);
            #1;
            if (ch1_rd_burst_data_valid) n1++;
            if (ch0_rd_burst_data_valid) n0++;
            if (ch0_rd_burst_data !== 64'(i * 3 + 7) || ch1_rd_burst_data !== 64'(i * 3 + 7)) nbad++;
            if (ch0_wr_burst_finish || ch1_wr_burst_finish) nleak++;
            cyc();
        end
        rd_burst_data_valid = 0; wr_burst_finish = 0;
        chk("t3_ch1_valid_count", 64'(n1), 64'd32);
        chk("t3_ch0_valid_count", 64'(n0), 64'd0);
        chk("t3_rd_data_broadcast_errors", 64'(nbad), 64'd0);
        chk("t3_stray_finish_leak", 64'(nleak), 64'd0);
        chk("t3_still_busy_grant", arb_grant, 4'b1000);
        chk("t3_still_busy_req", rd_burst_req, 1'b1);
        rd_burst_finish = 1;
        #1;
        chk("t3_ch1_rd_finish", ch1_rd_burst_finish, 1'b1);
        chk("t3_ch0_rd_finish", ch0_rd_burst_finish, 1'b0);
        cyc();
        rd_burst_finish = 0; ch1_rd_burst_req = 0;
        chk("t3_rd_req_after", rd_burst_req, 1'b0);
        chk("t3_arb_after", arb_grant, 4'b0000);

        // ch0_rd drops its request mid-burst
        ch0_rd_burst_req = 1;
        cyc();
        chk("t4_arb_grant", arb_grant, 4'b0010);
        ch0_rd_burst_req = 0;
        cyc(); cyc(); cyc();
        chk("t4_req_held", rd_burst_req, 1'b1);
        chk("t4_grant_held", arb_grant, 4'b0010);
        rd_burst_finish = 1;
        cyc();
        rd_burst_finish = 0;
        chk("t4_req_after", rd_burst_req, 1'b0);
        chk("t4_arb_after", arb_grant, 4'b0000);
        cyc();
        chk("t4_no_regrant", arb_grant, 4'b0000);

        // Reset during BUSY, then rr_ptr restarts at 0
        ch1_wr_burst_req = 1;
        cyc();
        chk("t6_arb_grant", arb_grant, 4'b0100);
        chk("t6_wr_req", wr_burst_req, 1'b1);
        rst = 1; ch0_rd_burst_req = 1;
        cyc();
        chk("t6_reset_reqs", {rd_burst_req, wr_burst_req}, 2'b00);
        chk("t6_reset_arb", arb_grant, 4'b0000);
        rst = 0;
        cyc();
        chk("t6_ptr_reset_pick", arb_grant, 4'b0010);
        rd_burst_finish = 1;
        cyc();
        rd_burst_finish = 0; ch0_rd_burst_req = 0;
        chk("t6_idle_gap", arb_grant, 4'b0000);
        cyc();
        chk("t6_regrant_ch1_wr", arb_grant, 4'b0100);
        chk("t6_regrant_wr_req", wr_burst_req, 1'b1);
        chk("t6_regrant_addr", wr_burst_addr, 25'h300);
        chk("t6_regrant_len", wr_burst_len, 10'd32);
        wr_burst_finish = 1;
        cyc();
        wr_burst_finish = 0; ch1_wr_burst_req = 0;
        chk("t6_final_wr_req", wr_burst_req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
